// File: rtl/seg_pkg.sv
// Shared 7-segment constants and scan-FSM encoding for the display-path encoders and decoders.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK   = 4'hF;
    localparam logic [3:0] CODE_INVALID = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_st_t;

endpackage

// File: rtl/seg_code_to_num.sv
// Combinational inverse lookup of an active-low segment pattern to a BCD/blank/invalid code.
// Zero latency, no flow control.
module seg_code_to_num
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_invalid
);

    always_comb begin
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = CODE_BLANK;
            default: begin
                o_code    = CODE_INVALID;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit codes/dp from a scanned active-low 7-segment bus; outputs load one edge after
// the sample completing the CONFIRM-th identical frame. Pure snooper: no backpressure on the bus.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int SETTLE  = 4,
    parameter int CONFIRM = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_seg,
    input  logic [DIGITS-1:0]     i_dig_sel,
    output logic [4*DIGITS-1:0]   o_digits,
    output logic [DIGITS-1:0]     o_dp,
    output logic                  o_frame_vld,
    output logic                  o_err
);

    localparam int CNT_W  = $clog2(SETTLE + 1);
    localparam int CNF_W  = $clog2(CONFIRM + 1);
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    scan_st_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [7:0]           r_seg_q;
    logic [DIGITS-1:0]    r_sel_q;
    logic [4*DIGITS-1:0]  r_frm_code, r_prv_code;
    logic [DIGITS-1:0]    r_frm_dp, r_prv_dp, r_mask;
    logic [CNF_W-1:0]     r_conf, w_conf_nxt;
    logic                 w_onehot, w_chg, w_sample, w_done, w_invalid;
    logic [3:0]           w_code, w_nlow;
    logic [SLOT_W-1:0]    w_slot;

    seg_code_to_num u_lookup (
        .i_seg     (i_seg[6:0]),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    always_comb begin
        w_nlow = '0;
        w_slot = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!i_dig_sel[k]) begin
                w_nlow = w_nlow + 4'd1;
                w_slot = SLOT_W'(k);
            end
        end
        w_onehot = (w_nlow == 4'd1);
        w_chg    = (i_seg != r_seg_q) || (i_dig_sel != r_sel_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_seg_q <= '1;
            r_sel_q <= '1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seg_q <= i_seg;
            r_sel_q <= i_dig_sel;
        end
    end

    // The count is the number of consecutive edges the current one-hot value has been seen.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_onehot) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (!w_onehot) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_chg) begin
                    w_cnt_nxt = CNT_W'(1);
                end else if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!w_onehot) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_chg) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sample = (r_state == ST_SETTLE) && w_onehot && !w_chg
                   && (r_cnt == CNT_W'(SETTLE - 1));
    end

    always_comb begin
        w_done = &r_mask;
        if ((r_frm_code == r_prv_code) && (r_frm_dp == r_prv_dp)) begin
            w_conf_nxt = (r_conf == CNF_W'(CONFIRM)) ? r_conf : r_conf + CNF_W'(1);
        end else begin
            w_conf_nxt = CNF_W'(1);
        end
    end

    // A sample on the completion edge lands after the mask clear, so it starts the new frame.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frm_code  <= {DIGITS{CODE_BLANK}};
            r_frm_dp    <= '0;
            r_mask      <= '0;
            r_prv_code  <= {DIGITS{CODE_BLANK}};
            r_prv_dp    <= '0;
            r_conf      <= '0;
            o_digits    <= {DIGITS{CODE_BLANK}};
            o_dp        <= '0;
            o_frame_vld <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_frame_vld <= 1'b0;
            o_err       <= w_sample & w_invalid;
            if (w_done) begin
                r_mask     <= '0;
                r_prv_code <= r_frm_code;
                r_prv_dp   <= r_frm_dp;
                r_conf     <= w_conf_nxt;
                if (w_conf_nxt == CNF_W'(CONFIRM)) begin
                    o_digits    <= r_frm_code;
                    o_dp        <= r_frm_dp;
                    o_frame_vld <= 1'b1;
                end
            end
            if (w_sample) begin
                r_frm_code[w_slot*4 +: 4] <= w_code;
                r_frm_dp[w_slot]          <= ~i_seg[7];
                r_mask[w_slot]            <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed plus randomized scans of seg_scan_decoder, checked every cycle against a dwell/frame model.
module tb_seg_scan_decoder;

    localparam int DIGITS  = 4;
    localparam int SETTLE  = 4;
    localparam int CONFIRM = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  seg = 8'hFF;
    logic [3:0]  dig_sel = 4'hF;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        frame_vld;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int vld_seen = 0;

    logic [6:0] pat7 [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Reference state: dwell run length, captured frame, previous frame, confirmation count.
    int          run;
    logic [7:0]  pseg;
    logic [3:0]  psel;
    int          fr_code [4];
    int          fr_dp   [4];
    int          pv_code [4];
    int          pv_dp   [4];
    bit          mask    [4];
    int          conf;
    logic [15:0] e_digits;
    logic [3:0]  e_dp;
    logic        e_vld, e_err;

    always #5 clk = ~clk;

    seg_scan_decoder #(.DIGITS(DIGITS), .SETTLE(SETTLE), .CONFIRM(CONFIRM)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_seg       (seg),
        .i_dig_sel   (dig_sel),
        .o_digits    (digits),
        .o_dp        (dp),
        .o_frame_vld (frame_vld),
        .o_err       (err)
    );

    function automatic int dec(input logic [6:0] p, output bit bad);
        bad = 1'b0;
        if (p == 7'h7F) return 15;
        for (int i = 0; i < 10; i++) if (pat7[i] == p) return i;
        bad = 1'b1;
        return 14;
    endfunction

    function automatic logic [3:0] sel_of(input int dg);
        logic [3:0] one;
        one = 4'b0001 << dg;
        return ~one;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] s, input logic [3:0] d);
        bit all, same, bad;
        int slot, nlow, code;
        e_vld = 1'b0;
        e_err = 1'b0;
        if (r) begin
            run = 0; conf = 0;
            for (int i = 0; i < 4; i++) begin
                mask[i] = 1'b0; fr_code[i] = 15; fr_dp[i] = 0; pv_code[i] = 15; pv_dp[i] = 0;
            end
            e_digits = 16'hFFFF;
            e_dp     = 4'h0;
            return;
        end
        all = 1'b1;
        for (int i = 0; i < 4; i++) if (!mask[i]) all = 1'b0;
        if (all) begin
            same = 1'b1;
            for (int i = 0; i < 4; i++)
                if (fr_code[i] != pv_code[i] || fr_dp[i] != pv_dp[i]) same = 1'b0;
            conf = same ? ((conf < CONFIRM) ? conf + 1 : conf) : 1;
            for (int i = 0; i < 4; i++) begin
                pv_code[i] = fr_code[i]; pv_dp[i] = fr_dp[i]; mask[i] = 1'b0;
            end
            if (conf == CONFIRM) begin
                for (int i = 0; i < 4; i++) begin
                    e_digits[4*i +: 4] = 4'(fr_code[i]);
                    e_dp[i]            = (fr_dp[i] != 0);
                end
                e_vld = 1'b1;
            end
        end
        if (run > 0 && s == pseg && d == psel) run++;
        else run = 1;
        pseg = s;
        psel = d;
        nlow = 0; slot = 0;
        for (int i = 0; i < 4; i++) if (!d[i]) begin nlow++; slot = i; end
        if (nlow == 1 && run == SETTLE) begin
            code          = dec(s[6:0], bad);
            fr_code[slot] = code;
            fr_dp[slot]   = s[7] ? 0 : 1;
            mask[slot]    = 1'b1;
            e_err         = bad;
        end
    endtask

    task automatic cyc(input logic [7:0] s, input logic [3:0] d, input logic r);
        seg = s; dig_sel = d; rst = r;
        @(posedge clk);
        model_step(r, s, d);
        #1;
        chk("digits", digits, e_digits);
        chk("dp", dp, e_dp);
        chk("frame_vld", frame_vld, e_vld);
        chk("err", err, e_err);
        if (frame_vld) vld_seen++;
    endtask

    task automatic dwell(input logic [7:0] s, input int dg, input int n);
        repeat (n) cyc(s, sel_of(dg), 1'b0);
    endtask

    task automatic scan(input logic [7:0] fs [4], input int n);
        for (int dg = 0; dg < 4; dg++) dwell(fs[dg], dg, n);
    endtask

    task automatic rand_frame();
        logic [7:0] fs [4];
        logic [6:0] p;
        int k, reps;
        for (int i = 0; i < 4; i++) begin
            k = $urandom_range(0, 9);
            if (k < 8)       p = pat7[$urandom_range(0, 9)];
            else if (k == 8) p = 7'h7F;
            else             p = 7'($urandom);
            fs[i] = {($urandom_range(0, 3) != 0), p};
        end
        reps = $urandom_range(1, 3);
        repeat (reps) begin
            for (int dg = 0; dg < 4; dg++) begin
                if ($urandom_range(0, 7) == 0)
                    repeat ($urandom_range(1, 3)) cyc(fs[dg], 4'($urandom_range(0, 15)), 1'b0);
                if ($urandom_range(0, 5) == 0)
                    dwell({1'b1, pat7[$urandom_range(0, 9)]}, dg, $urandom_range(1, 3));
                dwell(fs[dg], dg, $urandom_range(2, 9));
            end
        end
        if ($urandom_range(0, 15) == 0) cyc(8'hFF, 4'hF, 1'b1);
    endtask

    initial begin
        logic [7:0] fa [4];

        cyc(8'hFF, 4'hF, 1'b1);
        cyc(8'hFF, 4'hF, 1'b1);
        chk("rst_digits", digits, 16'hFFFF);
        chk("rst_dp", dp, 4'h0);
        chk("rst_vld", frame_vld, 1'b0);
        chk("rst_err", err, 1'b0);

        // Clean scan of 1,2,3,4 twice.
        vld_seen = 0;
        fa = '{8'hF9, 8'hA4, 8'hB0, 8'h99};
        scan(fa, 8);
        scan(fa, 8);
        repeat (3) cyc(8'hFF, 4'hF, 1'b0);
        chk("clean_vld_count", vld_seen, 1);
        chk("clean_digits", digits, 16'h4321);
        chk("clean_dp", dp, 4'h0);

        // Glitch on cycle 3 then a short 3-cycle dwell.
        dwell(8'hC0, 0, 2);
        dwell(8'hF9, 0, 5);
        dwell(8'hA4, 1, 3);
        dwell(8'hB0, 2, 6);

        // Invalid pattern on digit 2, confirmed twice.
        cyc(8'hFF, 4'hF, 1'b1);
        fa = '{8'hC0, 8'hF9, 8'h7E, 8'hA4};
        scan(fa, 6);
        scan(fa, 6);
        cyc(8'hFF, 4'hF, 1'b0);
        chk("invalid_digit2", digits[11:8], 4'hE);

        // Blank digit 0 and lit dp on digit 1.
        fa = '{8'hFF, 8'h40, 8'hFF, 8'hFF};
        scan(fa, 5);
        scan(fa, 5);
        cyc(8'hFF, 4'hF, 1'b0);
        chk("blank_digit0", digits[3:0], 4'hF);
        chk("zero_digit1", digits[7:4], 4'h0);
        chk("blank_dp", dp, 4'b0010);

        // Illegal selects hold everything.
        repeat (20) cyc(8'hF9, 4'b1100, 1'b0);
        repeat (20) cyc(8'hF9, 4'b1111, 1'b0);
        chk("illegal_digits", digits, 16'hFF0F);

        // Reset after two captured digits, then one and two full scans.
        dwell(8'hF9, 0, 8);
        dwell(8'hF9, 1, 8);
        cyc(8'hF9, sel_of(1), 1'b1);
        vld_seen = 0;
        fa = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        scan(fa, 6);
        cyc(8'hFF, 4'hF, 1'b0);
        chk("rst_mid_vld", vld_seen, 0);
        chk("rst_mid_digits", digits, 16'hFFFF);
        scan(fa, 6);
        scan(fa, 6);
        cyc(8'hFF, 4'hF, 1'b0);
        chk("rst_mid_after", digits, 16'h3210);

        repeat (40) rand_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
